// File: rtl/timer_pkg.sv
// Shared types and limits for the programmable interval timer bank.
package timer_pkg;

  typedef enum logic {T_IDLE, T_RUN} tstate_t;
  typedef enum logic {M_PERIODIC, M_ONESHOT} tmode_t;

  localparam int NCH_MAX = 16;

endpackage

// File: rtl/timer_channel.sv
// One interval timer: start/stop FSM, tick-gated counter, latched terminal/mode
// and a sticky expiry flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             irq_pend
);

  tstate_t          state;
  tmode_t           mode_q;
  logic [WIDTH-1:0] term_q;
  logic             hit;

  // A terminal hit only counts when no start/stop is competing for the same edge.
  assign hit     = (state == T_RUN) && tick_en && (count == term_q) && !start && !stop;
  assign running = (state == T_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= T_IDLE;
      mode_q  <= M_PERIODIC;
      term_q  <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (stop) begin
        state <= T_IDLE;
        count <= '0;
      end else if (start) begin
        term_q <= term;
        mode_q <= tmode_t'(mode);
        count  <= '0;
        state  <= T_RUN;
      end else if (hit) begin
        count   <= '0;
        expired <= 1'b1;
        if (mode_q == M_ONESHOT) state <= T_IDLE;
      end else if (state == T_RUN && tick_en) begin
        count <= count + WIDTH'(1);
      end
    end
  end

  // Setting the pending flag takes priority over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)        irq_pend <= 1'b0;
    else if (hit)     irq_pend <= 1'b1;
    else if (irq_clr) irq_pend <= 1'b0;
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent interval timers sharing one prescaler strobe;
// unpacks per-channel controls, packs results and forms the combined irq.
module timer_bank
  import timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_en,
  input  logic [NCH-1:0]       start,
  input  logic [NCH-1:0]       stop,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] term,
  input  logic [NCH-1:0]       irq_en,
  input  logic [NCH-1:0]       irq_clr,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       running,
  output logic [NCH-1:0]       expired,
  output logic [NCH-1:0]       irq_pend,
  output logic                 irq
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick_en  (tick_en),
      .start    (start[i]),
      .stop     (stop[i]),
      .mode     (mode[i]),
      .term     (term[i*WIDTH +: WIDTH]),
      .irq_clr  (irq_clr[i]),
      .count    (count[i*WIDTH +: WIDTH]),
      .running  (running[i]),
      .expired  (expired[i]),
      .irq_pend (irq_pend[i])
    );
  end

  assign irq = |(irq_pend & irq_en);

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a cycle model queues expected outputs as
// stimulus is applied, and each sampled cycle is checked against the queue.
module tb_timer_bank;

  localparam int NCH   = 4;
  localparam int WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 tick_en = 1'b0;
  logic [NCH-1:0]       start = '0, stop = '0, mode = '0, irq_en = '0, irq_clr = '0;
  logic [NCH*WIDTH-1:0] term = '0;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       running, expired, irq_pend;
  logic                 irq;

  typedef struct {
    logic [31:0]    count;
    logic [NCH-1:0] running;
    logic [NCH-1:0] expired;
    logic [NCH-1:0] pend;
    logic           irq;
  } exp_t;

  exp_t sb[$];

  logic             m_run [NCH];
  logic             m_one [NCH];
  logic             m_pend[NCH];
  logic [WIDTH-1:0] m_cnt [NCH];
  logic [WIDTH-1:0] m_term[NCH];

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  timer_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .start(start), .stop(stop),
    .mode(mode), .term(term), .irq_en(irq_en), .irq_clr(irq_clr),
    .count(count), .running(running), .expired(expired), .irq_pend(irq_pend),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, want);
    end
  endtask

  // Model one clock edge from the currently driven inputs and queue the result.
  task automatic predict();
    exp_t e;
    e.count = '0; e.running = '0; e.expired = '0; e.pend = '0;
    for (int i = 0; i < NCH; i++) begin
      logic fire;
      fire = 1'b0;
      if (reset) begin
        m_run[i] = 0; m_cnt[i] = '0; m_term[i] = '0; m_one[i] = 0; m_pend[i] = 0;
      end else begin
        if (stop[i]) begin
          m_run[i] = 0; m_cnt[i] = '0;
        end else if (start[i]) begin
          m_term[i] = term[i*WIDTH +: WIDTH]; m_one[i] = mode[i];
          m_cnt[i] = '0; m_run[i] = 1;
        end else if (m_run[i] && tick_en) begin
          if (m_cnt[i] == m_term[i]) begin
            fire = 1'b1; m_cnt[i] = '0;
            if (m_one[i]) m_run[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        if (fire) m_pend[i] = 1;
        else if (irq_clr[i]) m_pend[i] = 0;
      end
      e.count[i*WIDTH +: WIDTH] = m_cnt[i];
      e.running[i] = m_run[i];
      e.expired[i] = fire;
      e.pend[i]    = m_pend[i];
    end
    e.irq = |(e.pend & irq_en);
    sb.push_back(e);
  endtask

  task automatic scoreCycle();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("count",    count,    e.count);
      checkOutput("running",  running,  e.running);
      checkOutput("expired",  expired,  e.expired);
      checkOutput("irq_pend", irq_pend, e.pend);
      checkOutput("irq",      irq,      e.irq);
    end
  endtask

  task automatic applyStimulus();
    predict();
    @(posedge clk);
    #1;
    cyc++;
    scoreCycle();
    start = '0; stop = '0; irq_clr = '0;
  endtask

  task automatic setTerm(input int ch, input int val);
    term[ch*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  task automatic stopAll();
    stop = '1; irq_clr = '1;
    applyStimulus();
  endtask

  initial begin
    int s, n, at;
    logic [NCH-1:0] seen;

    // Reset state
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_running", running, '0);
    checkOutput("rst_count", count, '0);
    reset = 1'b0;
    applyStimulus();

    // Periodic ch0, term 3: strobes 4, 8, 12 cycles after start
    tick_en = 1; setTerm(0, 3); mode[0] = 0; start[0] = 1;
    applyStimulus();
    s = cyc; n = 0;
    for (int j = 0; j < 13; j++) begin
      applyStimulus();
      if (expired[0]) begin
        n++;
        checkOutput("t1_at", cyc - s, 4 * n);
      end
    end
    checkOutput("t1_n", n, 3);
    checkOutput("t1_run", running[0], 1);
    stopAll();

    // One-shot ch1, term 5: single strobe 6 cycles after start
    setTerm(1, 5); mode[1] = 1; start[1] = 1;
    applyStimulus();
    s = cyc; n = 0; at = 0;
    for (int j = 0; j < 12; j++) begin
      applyStimulus();
      if (expired[1]) begin n++; at = cyc - s; end
    end
    checkOutput("t2_n", n, 1);
    checkOutput("t2_at", at, 6);
    checkOutput("t2_run", running[1], 0);
    stopAll();

    // Gated ticks on ch3, term 2, tick every 3rd cycle: strobe after 9 clocks
    tick_en = 0; setTerm(3, 2); mode[3] = 0; start[3] = 1;
    applyStimulus();
    s = cyc; at = 0;
    for (int j = 1; j <= 10; j++) begin
      tick_en = (j % 3 == 0);
      applyStimulus();
      if (expired[3] && at == 0) at = cyc - s;
    end
    checkOutput("t3_at", at, 9);
    tick_en = 1;
    stopAll();

    // Collisions on ch0
    setTerm(0, 7); start[0] = 1; stop[0] = 1;
    applyStimulus();
    checkOutput("t4_ss_run", running[0], 0);
    setTerm(0, 1); mode[0] = 0; start[0] = 1;
    applyStimulus();
    applyStimulus();
    irq_clr[0] = 1;
    applyStimulus();
    checkOutput("t4_clr_exp", expired[0], 1);
    checkOutput("t4_clr_pend", irq_pend[0], 1);
    applyStimulus();
    start[0] = 1;
    applyStimulus();
    checkOutput("t4_rs_exp", expired[0], 0);
    checkOutput("t4_rs_cnt", count[WIDTH-1:0], 0);
    setTerm(0, 0);
    for (int j = 0; j < 4; j++) applyStimulus();
    start[0] = 1;
    applyStimulus();
    for (int j = 0; j < 3; j++) begin
      applyStimulus();
      checkOutput("t4_t0_exp", expired[0], 1);
    end
    stopAll();

    // Full range on ch3: term 255 strobes 256 cycles after start
    setTerm(3, 255); start[3] = 1;
    applyStimulus();
    s = cyc; at = 0;
    for (int j = 0; j < 258; j++) begin
      applyStimulus();
      if (expired[3] && at == 0) at = cyc - s;
    end
    checkOutput("t4_full_at", at, 256);
    stopAll();

    // IRQ enable/clear on ch2
    irq_en = '0; setTerm(2, 2); mode[2] = 0; start[2] = 1;
    applyStimulus();
    for (int j = 0; j < 3; j++) applyStimulus();
    stop[2] = 1;
    applyStimulus();
    checkOutput("t5_pend", irq_pend[2], 1);
    checkOutput("t5_irq_off", irq, 0);
    irq_en[2] = 1;
    applyStimulus();
    checkOutput("t5_irq_on", irq, 1);
    irq_clr[2] = 1;
    applyStimulus();
    checkOutput("t5_cleared", irq_pend[2], 0);
    checkOutput("t5_irq_clr", irq, 0);

    // Reset mid-run with every channel counting
    for (int i = 0; i < NCH; i++) setTerm(i, 10);
    mode = '0; start = '1;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    reset = 1;
    applyStimulus();
    checkOutput("t6_run", running, '0);
    reset = 0;
    seen = '0;
    for (int j = 0; j < 14; j++) begin
      applyStimulus();
      seen |= expired;
    end
    checkOutput("t6_noexp", seen, '0);

    // Random traffic against the model
    for (int j = 0; j < 600; j++) begin
      tick_en = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NCH; i++) begin
        start[i]   = ($urandom_range(0, 15) == 0);
        stop[i]    = ($urandom_range(0, 29) == 0);
        irq_clr[i] = ($urandom_range(0, 9) == 0);
        mode[i]    = $urandom_range(0, 1);
        irq_en[i]  = $urandom_range(0, 1);
        setTerm(i, $urandom_range(0, 6));
      end
      applyStimulus();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
